// File: rtl/multicycle_cpu_ctrl_if.sv
// multicycle_cpu_ctrl_if: instruction and data memory req/ready buses of the multi-cycle sequencer.
interface multicycle_cpu_ctrl_if #(
   parameter int XLEN = 32
);
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ready;
   logic [31:0]     imem_rdata;
   logic            dmem_req;
   logic            dmem_we;
   logic [XLEN-1:0] dmem_addr;
   logic [XLEN-1:0] dmem_wdata;
   logic            dmem_ready;
   logic [XLEN-1:0] dmem_rdata;
   modport master (
      output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  imem_ready, imem_rdata, dmem_ready, dmem_rdata
   );
   modport slave (
      input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output imem_ready, imem_rdata, dmem_ready, dmem_rdata
   );
endinterface

// File: rtl/multicycle_cpu_ctrl.sv
// multicycle_cpu_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core.
// Owns pc, ir and the cycle/instret counters; both memories use a req/ready handshake.
module multicycle_cpu_ctrl #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              CNT_W    = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   multicycle_cpu_ctrl_if.master bus,
   output logic [31:0]           ir,
   output logic [XLEN-1:0]       pc,
   input  logic                  reg_we,
   input  logic                  is_load,
   input  logic                  is_store,
   input  logic                  is_halt,
   input  logic [XLEN-1:0]       npc,
   input  logic [XLEN-1:0]       alu_result,
   input  logic [XLEN-1:0]       regdata2,
   output logic                  rf_we,
   output logic [XLEN-1:0]       rf_wdata,
   output logic                  halted,
   output logic                  misalign,
   output logic [CNT_W-1:0]      cycle_cnt,
   output logic [CNT_W-1:0]      instret_cnt
);
   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
   state_t          state;
   logic [XLEN-1:0] res_q;
   logic [XLEN-1:0] st_q;
   logic [XLEN-1:0] npc_q;
   logic            reg_we_q;
   logic            is_load_q;
   assign bus.imem_addr  = pc;
   assign bus.dmem_addr  = res_q;
   assign bus.dmem_wdata = st_q;
   // Request flops reset asynchronously, so an in-flight handshake is dropped the moment rst rises.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= FETCH;
         pc           <= RESET_PC;
         ir           <= '0;
         res_q        <= '0;
         st_q         <= '0;
         npc_q        <= '0;
         reg_we_q     <= 1'b0;
         is_load_q    <= 1'b0;
         bus.imem_req <= 1'b0;
         bus.dmem_req <= 1'b0;
         bus.dmem_we  <= 1'b0;
         rf_we        <= 1'b0;
         rf_wdata     <= '0;
         halted       <= 1'b0;
         misalign     <= 1'b0;
         cycle_cnt    <= '0;
         instret_cnt  <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 1'b1;
         rf_we     <= 1'b0;
         case (state)
            FETCH: begin
               bus.imem_req <= 1'b1;
               if (bus.imem_req && bus.imem_ready) begin
                  ir           <= bus.imem_rdata;
                  bus.imem_req <= 1'b0;
                  state        <= DECODE;
               end
            end
            DECODE: state <= EXEC;
            EXEC: begin
               res_q     <= alu_result;
               st_q      <= regdata2;
               npc_q     <= npc;
               reg_we_q  <= reg_we;
               is_load_q <= is_load;
               if (is_halt) begin
                  halted <= 1'b1;
                  state  <= HALT;
               end else if (npc[1:0] != 2'b00) begin
                  halted   <= 1'b1;
                  misalign <= 1'b1;
                  state    <= HALT;
               end else if (is_load || is_store) begin
                  bus.dmem_req <= 1'b1;
                  bus.dmem_we  <= is_store;
                  state        <= MEM;
               end else begin
                  rf_we    <= reg_we;
                  rf_wdata <= alu_result;
                  state    <= WB;
               end
            end
            MEM: begin
               if (bus.dmem_req && bus.dmem_ready) begin
                  bus.dmem_req <= 1'b0;
                  bus.dmem_we  <= 1'b0;
                  rf_we        <= reg_we_q;
                  rf_wdata     <= is_load_q ? bus.dmem_rdata : res_q;
                  state        <= WB;
               end
            end
            WB: begin
               pc           <= npc_q;
               instret_cnt  <= instret_cnt + 1'b1;
               bus.imem_req <= 1'b1;
               state        <= FETCH;
            end
            default: ;
         endcase
      end
   end
endmodule
